// File: rtl/mul_div.sv
// mul_div: iterative RV32M multiply/divide unit for the execute stage.
// The unit latches the opcode and operands when it starts. It then runs
// 32 shift-add (multiply) and restoring-divide iterations in parallel.
// After that it presents a registered result together with a one-cycle
// ready pulse.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-low reset
//   inst_i         decoded instruction code (OP_* parameters)
//   muldiv_inst_i  current execute instruction is an M-extension op
//   reg1_data_i    rs1 operand (multiplicand / dividend)
//   reg2_data_i    rs2 operand (multiplier / divisor)
//   data_o         registered result, held until the next completion
//   ready_o        result valid, one-cycle pulse (state DONE)
//   exception_o    divide-by-zero or unknown opcode, valid with ready_o
module mul_div #(
    parameter logic [7:0] OP_MUL    = 8'h30,
    parameter logic [7:0] OP_MULH   = 8'h31,
    parameter logic [7:0] OP_MULHSU = 8'h32,
    parameter logic [7:0] OP_MULHU  = 8'h33,
    parameter logic [7:0] OP_DIV    = 8'h34,
    parameter logic [7:0] OP_DIVU   = 8'h35,
    parameter logic [7:0] OP_REM    = 8'h36,
    parameter logic [7:0] OP_REMU   = 8'h37
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  inst_i,
    input  logic        muldiv_inst_i,
    input  logic [31:0] reg1_data_i,
    input  logic [31:0] reg2_data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        exception_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_r, state_nxt_s;
    logic [4:0]  cnt_r;
    logic [7:0]  op_r;
    logic        neg_a_r, neg_b_r, div_zero_r;
    logic [31:0] dividend_r;
    logic [63:0] mcand_r, acc_r;
    logic [31:0] mplier_r;
    logic [31:0] rem_r, quo_r, divisor_r;
    logic [31:0] data_r;
    logic        exception_r;

    logic        start_s, last_iter_s;
    logic        a_signed_s, b_signed_s, neg_a_s, neg_b_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [63:0] acc_nxt_s, prod_s;
    logic [32:0] trial_s;
    logic [31:0] rem_nxt_s, quo_nxt_s, quo_fin_s, rem_fin_s;
    logic [31:0] result_s;
    logic        result_exc_s;

    assign start_s     = (state_r == ST_IDLE) && muldiv_inst_i;
    assign last_iter_s = (state_r == ST_BUSY) && (cnt_r == 5'd31);

    // Operand signedness decode and magnitude formation at start.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (inst_i)
            OP_MULH:        begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            OP_MULHSU:      begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            OP_DIV, OP_REM: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        neg_a_s = a_signed_s & reg1_data_i[31];
        neg_b_s = b_signed_s & reg2_data_i[31];
        a_mag_s = neg_a_s ? (32'd0 - reg1_data_i) : reg1_data_i;
        b_mag_s = neg_b_s ? (32'd0 - reg2_data_i) : reg2_data_i;
    end

    // One shift-add step and one restoring-divide step.
    always_comb begin
        acc_nxt_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        // The shifted partial remainder always fits in 33 bits because rem_r < divisor.
        trial_s   = {rem_r, quo_r[31]} - {1'b0, divisor_r};
        if (!trial_s[32]) begin
            rem_nxt_s = trial_s[31:0];
            quo_nxt_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_nxt_s = {rem_r[30:0], quo_r[31]};
            quo_nxt_s = {quo_r[30:0], 1'b0};
        end
    end

    // Sign correction, special cases and opcode select of the final result.
    always_comb begin
        prod_s = (neg_a_r ^ neg_b_r) ? (64'd0 - acc_nxt_s) : acc_nxt_s;
        if (div_zero_r) begin
            quo_fin_s = 32'hFFFF_FFFF;
            rem_fin_s = dividend_r;
        end else begin
            quo_fin_s = (neg_a_r ^ neg_b_r) ? (32'd0 - quo_nxt_s) : quo_nxt_s;
            rem_fin_s = neg_a_r ? (32'd0 - rem_nxt_s) : rem_nxt_s;
        end
        result_s     = 32'd0;
        result_exc_s = 1'b0;
        case (op_r)
            OP_MUL:                       result_s = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_s = prod_s[63:32];
            OP_DIV, OP_DIVU: begin
                result_s     = quo_fin_s;
                result_exc_s = div_zero_r;
            end
            OP_REM, OP_REMU: begin
                result_s     = rem_fin_s;
                result_exc_s = div_zero_r;
            end
            default: begin
                result_s     = 32'd0;
                result_exc_s = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = muldiv_inst_i ? ST_BUSY : ST_IDLE;
            ST_BUSY: state_nxt_s = (cnt_r == 5'd31) ? ST_DONE : ST_BUSY;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r       <= 5'd0;
            op_r        <= 8'd0;
            neg_a_r     <= 1'b0;
            neg_b_r     <= 1'b0;
            div_zero_r  <= 1'b0;
            dividend_r  <= 32'd0;
            mcand_r     <= 64'd0;
            acc_r       <= 64'd0;
            mplier_r    <= 32'd0;
            rem_r       <= 32'd0;
            quo_r       <= 32'd0;
            divisor_r   <= 32'd0;
            data_r      <= 32'd0;
            exception_r <= 1'b0;
        end else begin
            if (start_s) begin
                cnt_r      <= 5'd0;
                op_r       <= inst_i;
                neg_a_r    <= neg_a_s;
                neg_b_r    <= neg_b_s;
                div_zero_r <= (reg2_data_i == 32'd0);
                dividend_r <= reg1_data_i;
                mcand_r    <= {32'd0, a_mag_s};
                acc_r      <= 64'd0;
                mplier_r   <= b_mag_s;
                rem_r      <= 32'd0;
                quo_r      <= a_mag_s;
                divisor_r  <= b_mag_s;
            end else if (state_r == ST_BUSY) begin
                cnt_r    <= cnt_r + 5'd1;
                acc_r    <= acc_nxt_s;
                mcand_r  <= {mcand_r[62:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[31:1]};
                rem_r    <= rem_nxt_s;
                quo_r    <= quo_nxt_s;
            end else begin
                cnt_r <= cnt_r;
            end
            if (last_iter_s) begin
                data_r      <= result_s;
                exception_r <= result_exc_s;
            end else begin
                exception_r <= 1'b0;
            end
        end
    end

    assign data_o      = data_r;
    assign exception_o = exception_r;
    assign ready_o     = (state_r == ST_DONE);

endmodule

// File: tb/tb_mul_div.sv
module tb_mul_div;

    localparam logic [7:0] OP_MUL    = 8'h30;
    localparam logic [7:0] OP_MULH   = 8'h31;
    localparam logic [7:0] OP_MULHSU = 8'h32;
    localparam logic [7:0] OP_MULHU  = 8'h33;
    localparam logic [7:0] OP_DIV    = 8'h34;
    localparam logic [7:0] OP_DIVU   = 8'h35;
    localparam logic [7:0] OP_REM    = 8'h36;
    localparam logic [7:0] OP_REMU   = 8'h37;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  inst_i = 8'd0;
    logic        muldiv_inst_i = 1'b0;
    logic [31:0] reg1_data_i = 32'd0;
    logic [31:0] reg2_data_i = 32'd0;
    logic [31:0] data_o;
    logic        ready_o;
    logic        exception_o;

    mul_div dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inst_i        (inst_i),
        .muldiv_inst_i (muldiv_inst_i),
        .reg1_data_i   (reg1_data_i),
        .reg2_data_i   (reg2_data_i),
        .data_o        (data_o),
        .ready_o       (ready_o),
        .exception_o   (exception_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [32:0] exp_q[$];
    int unsigned start_q[$];
    int unsigned ready_q[$];
    int          check_cnt = 0;
    int          pass_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules.
    function automatic logic [32:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        r = 32'd0;
        e = 1'b0;
        p = 64'd0;
        case (op)
            OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
            OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            OP_DIV:    if (b == 32'd0) begin r = 32'hFFFF_FFFF; e = 1'b1; end
                       else begin p = sa / sb; r = p[31:0]; end
            OP_DIVU:   if (b == 32'd0) begin r = 32'hFFFF_FFFF; e = 1'b1; end
                       else r = a / b;
            OP_REM:    if (b == 32'd0) begin r = a; e = 1'b1; end
                       else begin p = sa % sb; r = p[31:0]; end
            OP_REMU:   if (b == 32'd0) begin r = a; e = 1'b1; end
                       else r = a % b;
            default:   begin r = 32'd0; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    // Monitor: every ready pulse is matched against the oldest expectation.
    logic [32:0] mon_e;
    int unsigned mon_s;
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (ready_o) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL unexpected_ready: ready_o=1 with no operation outstanding, required 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_s = start_q.pop_front();
                    chk("data", {32'd0, data_o}, {32'd0, mon_e[31:0]});
                    chk("exception", {63'd0, exception_o}, {63'd0, mon_e[32]});
                    chk("latency", 64'(cyc - mon_s), 64'd32);
                    ready_q.push_back(cyc);
                end
            end else if (exception_o) begin
                chk("exception_outside_done", {63'd0, exception_o}, 64'd0);
            end
        end
    end

    // Present an op just after an edge; the next edge is the start edge.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk_i);
        #1;
        inst_i        = op;
        reg1_data_i   = a;
        reg2_data_i   = b;
        muldiv_inst_i = 1'b1;
        exp_q.push_back(model(op, a, b));
        start_q.push_back(cyc + 1);
    endtask

    // Wait for the ready pulse; optionally disturb the inputs mid-operation.
    task automatic wait_ready(input bit scramble);
        int  k;
        bit  seen;
        k    = scramble ? int'($urandom_range(3, 25)) : 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk_i);
            if (ready_o) seen = 1'b1;
            else if (i == k) begin
                inst_i        = 8'($urandom);
                reg1_data_i   = $urandom;
                reg2_data_i   = $urandom;
                muldiv_inst_i = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) begin
            check_cnt++;
            $display("FAIL ready_timeout: no ready_o within 40 cycles, required a pulse");
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk_i);
        #1;
        muldiv_inst_i = 1'b0;
        repeat (n) @(posedge clk_i);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t directed[13] = '{
        '{OP_MUL,    32'd7,           32'd6},
        '{OP_MULH,   32'hFFFF_FFFF,   32'hFFFF_FFFF},
        '{OP_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF},
        '{OP_MULHSU, 32'hFFFF_FFFF,   32'd2},
        '{OP_DIV,    32'hFFFF_FFF9,   32'd2},
        '{OP_REM,    32'hFFFF_FFF9,   32'd2},
        '{OP_DIVU,   32'd100,         32'd7},
        '{OP_REMU,   32'd100,         32'd7},
        '{OP_DIV,    32'd5,           32'd0},
        '{OP_REM,    32'd5,           32'd0},
        '{OP_DIV,    32'h8000_0000,   32'hFFFF_FFFF},
        '{OP_REM,    32'h8000_0000,   32'hFFFF_FFFF},
        '{8'h00,     32'd9,           32'd9}
    };

    logic [7:0] rop;
    int         drain;

    initial begin
        // Reset state.
        #12;
        chk("reset_data", {32'd0, data_o}, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_exception", {63'd0, exception_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Directed cases, alternating back-to-back and idle gaps.
        for (int i = 0; i < 13; i++) begin
            issue(directed[i].op, directed[i].a, directed[i].b);
            wait_ready(1'b0);
            if (i % 2 == 1) idle(2);
        end
        idle(1);

        // Two back-to-back ops with muldiv_inst_i held high.
        ready_q.delete();
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_ready(1'b0);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'd3);
        wait_ready(1'b0);
        idle(1);
        if (ready_q.size() == 2) chk("b2b_spacing", 64'(ready_q[1] - ready_q[0]), 64'd34);
        else chk("b2b_pulse_count", 64'(ready_q.size()), 64'd2);

        // Reset mid-operation at iteration 10.
        issue(OP_MUL, 32'd12345, 32'd678);
        repeat (11) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midreset_data", {32'd0, data_o}, 64'd0);
        chk("midreset_ready", {63'd0, ready_o}, 64'd0);
        chk("midreset_exception", {63'd0, exception_o}, 64'd0);
        void'(exp_q.pop_back());
        void'(start_q.pop_back());
        muldiv_inst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        issue(OP_MUL, 32'd3, 32'd3);
        wait_ready(1'b0);
        idle(1);

        // Randomized ops with input disturbance during BUSY.
        for (int n = 0; n < 60; n++) begin
            rop = ($urandom_range(0, 9) < 8) ? (OP_MUL + 8'($urandom_range(0, 7))) : 8'($urandom);
            issue(rop, pick(), pick());
            wait_ready(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
        end
        idle(2);

        drain = 0;
        while (exp_q.size() != 0 && drain < 50) begin
            @(posedge clk_i);
            drain++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
